uart_tx_fifo: RTL and testbench

Buffered UART transmitter for the 50 MHz system clock. Generates its own bit timing from `clk`, so it needs no separate divided UART clock. Accepts bytes on a single-cycle write strobe into an internal FIFO and serialises them as 8N1 or 8-bit-plus-parity frames, LSB first. It sits on the transmit side of the UART loopback/control path and pairs with the existing receiver, whose parity check (`dataerror`) and stop-bit check (`frameerror`) it must satisfy.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 / 8-bit-plus-parity serialiser, LSB first.
// Bit timing is derived from clk by an internal baud counter.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned PARITY   = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic       wrsig,
  output logic       full,
  output logic       empty,
  output logic       idle,
  output logic       overflow,
  output logic       tx
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, empty_q, idle_q, ovf_q, ovf_d;
  state_e          state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d, rd_data;
  logic            par_q, par_d, tx_q, tx_d;
  logic            push, pop, bit_end;

  // Full is judged on the registered flag, so a write beside a pop while full is still dropped.
  assign push    = wrsig & ~full_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == CntW'(DIV - 1));

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (wrsig & full_q);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    if (state_q != StIdle) baud_d = bit_end ? '0 : baud_q + CntW'(1);
    case (state_q)
      StIdle: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (bit_end) begin
          bit_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != 0) ? StPar : StStop;
        end
      end
      StPar: begin
        tx_d = par_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d = rd_data;
      par_d   = (PARITY == 1) ? ~(^rd_data) : ^rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= datain;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      idle_q   <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(DEPTH));
      empty_q  <= (count_d == '0);
      idle_q   <= (state_q == StIdle) && empty_q;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign idle     = idle_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (no parity, even, odd) at DIV=16, DEPTH=4.
module tb_uart_tx_fifo;

  localparam int unsigned DIV = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       wr0 = 1'b0, wr1 = 1'b0, wr2 = 1'b0;
  logic       full0, empty0, idle0, overflow0, tx0;
  logic       full1, empty1, idle1, overflow1, tx1;
  logic       full2, empty2, idle2, overflow2, tx2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(160), .BAUD(10), .DEPTH(4), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .datain(datain), .wrsig(wr0), .full(full0), .empty(empty0),
    .idle(idle0), .overflow(overflow0), .tx(tx0));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD(10), .DEPTH(4), .PARITY(2)) u_dut_even (
    .clk(clk), .reset(reset), .datain(datain), .wrsig(wr1), .full(full1), .empty(empty1),
    .idle(idle1), .overflow(overflow1), .tx(tx1));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD(10), .DEPTH(4), .PARITY(1)) u_dut_odd (
    .clk(clk), .reset(reset), .datain(datain), .wrsig(wr2), .full(full2), .empty(empty2),
    .idle(idle2), .overflow(overflow2), .tx(tx2));

  function automatic logic cur_tx(input int sel);
    return (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic cur_idle(input int sel);
    return (sel == 0) ? idle0 : (sel == 1) ? idle1 : idle2;
  endfunction

  // Called on a negedge; the write is sampled at the next posedge, returns on the negedge after.
  task automatic write_byte(input int sel, input logic [7:0] d);
    datain = d;
    if (sel == 0) wr0 = 1'b1;
    else if (sel == 1) wr1 = 1'b1;
    else wr2 = 1'b1;
    @(negedge clk);
    wr0 = 1'b0;
    wr1 = 1'b0;
    wr2 = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples each bit near its middle.
  task automatic recv_frame(input int sel, input bit has_par, output logic [7:0] data,
                            output logic par, output logic start_b, output logic stop_b,
                            output int waited, output bit timeout);
    waited  = 0;
    timeout = 1'b0;
    data    = 8'h00;
    par     = 1'b0;
    start_b = 1'b1;
    stop_b  = 1'b0;
    while (cur_tx(sel) !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (cur_tx(sel) !== 1'b0) begin
      timeout = 1'b1;
      return;
    end
    repeat (DIV / 2 - 1) @(negedge clk);
    start_b = cur_tx(sel);
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      data[i] = cur_tx(sel);
    end
    if (has_par) begin
      repeat (DIV) @(negedge clk);
      par = cur_tx(sel);
    end
    repeat (DIV) @(negedge clk);
    stop_b = cur_tx(sel);
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx0, empty0, full0, idle0, overflow0} !== 5'b11010) begin
      errors++;
      $display("FAIL reset_state: got %b expected 11010", {tx0, empty0, full0, idle0, overflow0});
    end
    checks++;
    if ({tx1, tx2, empty1, empty2} !== 4'b1111) begin
      errors++;
      $display("FAIL reset_state_par: got %b expected 1111", {tx1, tx2, empty1, empty2});
    end
    write_byte(0, 8'hA5);
    checks++;
    if (empty0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_write_blocked: empty got %b expected 1", empty0);
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || empty0 !== 1'b1 || idle0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_nothing_stored: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_single();
    logic [7:0] d;
    logic p, s0, s1;
    int w;
    bit to;
    write_byte(0, 8'h55);
    checks++;
    if ({empty0, idle0, tx0} !== 3'b011) begin
      errors++;
      $display("FAIL single_edge_n: empty,idle,tx got %b expected 011", {empty0, idle0, tx0});
    end
    @(negedge clk);
    checks++;
    if ({empty0, idle0, tx0} !== 3'b101) begin
      errors++;
      $display("FAIL single_edge_n1: empty,idle,tx got %b expected 101", {empty0, idle0, tx0});
    end
    recv_frame(0, 1'b0, d, p, s0, s1, w, to);
    checks++;
    if (to || w != 1) begin
      errors++;
      $display("FAIL single_start_latency: got wait %0d timeout %0b expected 1 0", w, to);
    end
    checks++;
    if ({s0, d, s1} !== 10'b0_01010101_1) begin
      errors++;
      $display("FAIL single_frame: got start %b data %h stop %b expected 0 55 1", s0, d, s1);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (idle0 !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_early: got %b expected 0", idle0);
    end
    @(negedge clk);
    checks++;
    if (idle0 !== 1'b1) begin
      errors++;
      $display("FAIL single_idle_end: got %b expected 1", idle0);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d;
    logic p, s0, s1, exp_p, derr;
    int w;
    bit to;
    for (int sel = 1; sel <= 2; sel++) begin
      exp_p = (sel == 1) ? 1'b1 : 1'b0;  // 8'h07 has three ones
      write_byte(sel, 8'h07);
      @(negedge clk);
      recv_frame(sel, 1'b1, d, p, s0, s1, w, to);
      checks++;
      if (to || {s0, d, s1} !== 10'b0_00000111_1) begin
        errors++;
        $display("FAIL parity_frame%0d: got start %b data %h stop %b to %0b expected 0 07 1 0",
                 sel, s0, d, s1, to);
      end
      checks++;
      if (p !== exp_p) begin
        errors++;
        $display("FAIL parity_bit%0d: got %b expected %b", sel, p, exp_p);
      end
      derr = (sel == 1) ? (^d ^ p) : ~(^d ^ p);
      checks++;
      if (derr !== 1'b0) begin
        errors++;
        $display("FAIL parity_dataerror%0d: got %b expected 0", sel, derr);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (cur_idle(sel) !== 1'b0) begin
        errors++;
        $display("FAIL parity_len_early%0d: idle got %b expected 0", sel, cur_idle(sel));
      end
      @(negedge clk);
      checks++;
      if (cur_idle(sel) !== 1'b1) begin
        errors++;
        $display("FAIL parity_len_end%0d: idle got %b expected 1", sel, cur_idle(sel));
      end
    end
    checks++;
    if ({full1, overflow1, empty1, full2, overflow2, empty2} !== 6'b001001) begin
      errors++;
      $display("FAIL parity_flags: got %b expected 001001",
               {full1, overflow1, empty1, full2, overflow2, empty2});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_full = 6'b110000;  // index = write number - 1
    logic [5:0] exp_ovf  = 6'b100000;
    logic [7:0] d;
    logic p, s0, s1;
    int w, bad;
    bit to;
    for (int i = 0; i < 6; i++) begin
      write_byte(0, 8'(i + 1));
      checks++;
      if (full0 !== exp_full[i] || overflow0 !== exp_ovf[i]) begin
        errors++;
        $display("FAIL burst_flags%0d: full,ovf got %b%b expected %b%b", i, full0, overflow0,
                 exp_full[i], exp_ovf[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      recv_frame(0, 1'b0, d, p, s0, s1, w, to);
      checks++;
      if (to || {s0, d, s1} !== {1'b0, 8'(k + 1), 1'b1}) begin
        errors++;
        $display("FAIL burst_frame%0d: got start %b data %h stop %b to %0b expected 0 %h 1 0",
                 k, s0, d, s1, to, 8'(k + 1));
      end
      if (k > 0) begin
        checks++;
        if (w > DIV / 2 + 1) begin
          errors++;
          $display("FAIL burst_gap%0d: got %0d cycles expected <= %0d", k, w, DIV / 2 + 1);
        end
      end
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || idle0 !== 1'b1 || overflow0 !== 1'b1 || empty0 !== 1'b1) begin
      errors++;
      $display("FAIL burst_after: got low %0d idle %b ovf %b empty %b expected 0 1 1 1",
               bad, idle0, overflow0, empty0);
    end
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    write_byte(0, 8'hF0);
    repeat (70) @(negedge clk);  // inside data bit 3
    checks++;
    if (tx0 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_bit3: got %b expected 0", tx0);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx0, empty0, idle0} !== 3'b111) begin
      errors++;
      $display("FAIL midframe_reset: tx,empty,idle got %b expected 111", {tx0, empty0, idle0});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (250) begin
      @(negedge clk);
      if (tx0 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || idle0 !== 1'b1 || overflow0 !== 1'b0) begin
      errors++;
      $display("FAIL midframe_no_resume: got low %0d idle %b ovf %b expected 0 1 0",
               bad, idle0, overflow0);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d, exp_d;
    logic p, s0, s1;
    int w;
    bit to;
    for (int i = 0; i < 10; i++) begin
      exp_d = 8'(i * 53 + 17);
      write_byte(0, exp_d);
      recv_frame(0, 1'b0, d, p, s0, s1, w, to);
      checks++;
      if (to || {s0, d, s1} !== {1'b0, exp_d, 1'b1}) begin
        errors++;
        $display("FAIL wrap_frame%0d: got start %b data %h stop %b to %0b expected 0 %h 1 0",
                 i, s0, d, s1, to, exp_d);
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if ({idle0, empty0, overflow0} !== 3'b110) begin
      errors++;
      $display("FAIL wrap_end: idle,empty,ovf got %b expected 110", {idle0, empty0, overflow0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_reset_midframe();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
